// File: rtl/cpu_host_pkg.sv
// Shared opcodes, FSM encoding and response constants for the CPU host sequencer.
// No logic or state of its own; imported by cpu_host_ctrl and run_timer.
// Backpressure does not apply here.
package cpu_host_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WR_IMEM = 3'd1;
    localparam logic [2:0] OP_RD_IMEM = 3'd2;
    localparam logic [2:0] OP_WR_DMEM = 3'd3;
    localparam logic [2:0] OP_RD_DMEM = 3'd4;
    localparam logic [2:0] OP_RUN     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_CAPT,
        ST_RUN,
        ST_RSP
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    localparam rsp_t RSP_ERR = '{err: 1'b1, dat: 32'd0};

    // A word address is usable only if every bit above the memory's index width is zero.
    function automatic logic addr_fits(input logic [31:0] addr, input int unsigned width);
        return (addr >> width) == 32'd0;
    endfunction

endpackage

// File: rtl/run_timer.sv
// Loadable down-counter that opens a CPU enable window of up to N cycles.
// Enable rises the cycle after load; last is combinational on the final enabled cycle.
// No backpressure; abort cuts the window short at the current cycle.
module run_timer
    import cpu_host_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              abort,
    output logic              active,
    output logic              last,
    output logic [DATA_W-1:0] executed
);

    logic [DATA_W-1:0] remaining;

    assign last = active && (abort || (remaining == DATA_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            executed  <= '0;
            active    <= 1'b0;
        end else if (load) begin
            remaining <= load_val;
            executed  <= '0;
            active    <= (load_val != '0);
        end else if (active) begin
            remaining <= remaining - DATA_W'(1);
            executed  <= executed + DATA_W'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host command sequencer driving CPU enable and the IMEM/DMEM external ports.
// Write: response 2 cycles after accept; read: 3; RUN N: N+1; NOP/error/RUN 0: 1.
// One command in flight: cmd_ready only in IDLE; response held until rsp_ready.
module cpu_host_ctrl
    import cpu_host_pkg::*;
#(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [31:0]       cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              run_abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              running,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    input  logic [31:0]       rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [31:0]       wdata_ext_2,
    input  logic [31:0]       rdata_ext_2,
    output logic [DATA_W-1:0] cycle_count
);

    state_t            state_q, state_nxt;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
    logic              rsp_err_q, rsp_err_nxt, rsp_load;
    logic              tmr_load, tmr_active, tmr_last;
    logic [DATA_W-1:0] tmr_exec;
    logic              cmd_is_imem, op_is_imem, wr_cyc, rd_cyc;

    assign cmd_is_imem = (cmd_op == OP_WR_IMEM) || (cmd_op == OP_RD_IMEM);
    assign op_is_imem  = (op_q == OP_WR_IMEM) || (op_q == OP_RD_IMEM);

    run_timer #(.DATA_W(DATA_W)) u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (cmd_data),
        .abort    (run_abort),
        .active   (tmr_active),
        .last     (tmr_last),
        .executed (tmr_exec)
    );

    always_comb begin
        state_nxt    = state_q;
        rsp_load     = 1'b0;
        rsp_data_nxt = '0;
        rsp_err_nxt  = 1'b0;
        tmr_load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Default is an immediate zero response; writes keep it as their answer.
                    state_nxt = ST_RSP;
                    rsp_load  = 1'b1;
                    case (cmd_op)
                        OP_NOP: ;
                        OP_WR_IMEM, OP_RD_IMEM, OP_WR_DMEM, OP_RD_DMEM: begin
                            if (!addr_fits(cmd_addr, cmd_is_imem ? IMEM_ADDR_W : DMEM_ADDR_W)) begin
                                rsp_err_nxt  = RSP_ERR.err;
                                rsp_data_nxt = DATA_W'(RSP_ERR.dat);
                            end else if ((cmd_op == OP_WR_IMEM) || (cmd_op == OP_WR_DMEM)) begin
                                state_nxt = ST_WRITE;
                            end else begin
                                state_nxt = ST_RD_ISSUE;
                            end
                        end
                        OP_RUN: begin
                            if (cmd_data != '0) begin
                                state_nxt = ST_RUN;
                                tmr_load  = 1'b1;
                            end
                        end
                        default: begin
                            rsp_err_nxt  = RSP_ERR.err;
                            rsp_data_nxt = DATA_W'(RSP_ERR.dat);
                        end
                    endcase
                end
            end
            ST_WRITE:    state_nxt = ST_RSP;
            ST_RD_ISSUE: state_nxt = ST_RD_CAPT;
            ST_RD_CAPT: begin
                rsp_load     = 1'b1;
                rsp_data_nxt = DATA_W'(op_is_imem ? rdata_ext : rdata_ext_2);
                state_nxt    = ST_RSP;
            end
            ST_RUN: begin
                if (tmr_last) begin
                    rsp_load     = 1'b1;
                    rsp_data_nxt = tmr_exec + DATA_W'(1);
                    state_nxt    = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_q <= state_nxt;
            if (cmd_valid && cmd_ready) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
            if (rsp_load) begin
                rsp_data_q <= rsp_data_nxt;
                rsp_err_q  <= rsp_err_nxt;
            end
            if (cpu_enable) begin
                cycle_count <= cycle_count + DATA_W'(1);
            end
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RSP);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign cpu_enable = tmr_active;
    assign running    = tmr_active;

    assign wr_cyc = (state_q == ST_WRITE);
    assign rd_cyc = (state_q == ST_RD_ISSUE);

    assign wen_ext     = wr_cyc && op_is_imem;
    assign ren_ext     = rd_cyc && op_is_imem;
    assign addr_ext    = ((wr_cyc || rd_cyc) && op_is_imem) ? addr_q : 32'd0;
    assign wdata_ext   = (wr_cyc && op_is_imem) ? 32'(data_q) : 32'd0;
    assign wen_ext_2   = wr_cyc && !op_is_imem;
    assign ren_ext_2   = rd_cyc && !op_is_imem;
    assign addr_ext_2  = ((wr_cyc || rd_cyc) && !op_is_imem) ? addr_q : 32'd0;
    assign wdata_ext_2 = (wr_cyc && !op_is_imem) ? 32'(data_q) : 32'd0;

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Randomized bench for cpu_host_ctrl with behavioural memories and a command-level reference model.
module tb_cpu_host_ctrl;
    import cpu_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic        run_abort;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err, running, cpu_enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;
    logic [31:0] cycle_count;

    int n_chk = 0;
    int n_err = 0;

    cpu_host_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .run_abort(run_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .running(running), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency, as seen by the CPU's external ports.
    logic [31:0] imem [0:511];
    logic [31:0] dmem [0:1023];
    int n_wen_i = 0, n_ren_i = 0, n_wen_d = 0, n_ren_d = 0, n_bad_strobe = 0;

    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[8:0]]   <= wdata_ext;
        if (ren_ext)   rdata_ext             <= imem[addr_ext[8:0]];
        if (wen_ext_2) dmem[addr_ext_2[9:0]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2           <= dmem[addr_ext_2[9:0]];
        n_wen_i <= n_wen_i + int'(wen_ext);
        n_ren_i <= n_ren_i + int'(ren_ext);
        n_wen_d <= n_wen_d + int'(wen_ext_2);
        n_ren_d <= n_ren_d + int'(ren_ext_2);
        if (((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) ||
            (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) ||
            (!wen_ext && !ren_ext && (addr_ext != 0 || wdata_ext != 0)) ||
            (!wen_ext_2 && !ren_ext_2 && (addr_ext_2 != 0 || wdata_ext_2 != 0)))
            n_bad_strobe <= n_bad_strobe + 1;
    end

    // Reference model state: memory contents, written addresses, enabled-cycle total.
    logic [31:0] ref_imem [int];
    logic [31:0] ref_dmem [int];
    int          wi_q[$];
    int          wd_q[$];
    logic [31:0] exp_cc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int abort_at, input int hold);
        bit          imem_op, dmem_op, wr_op, rd_op, err, rdy_bad, stable_bad, first_en;
        int          exp_en, exp_lat, lat, en_seen, wi0, ri0, wd0, rd0;
        logic [31:0] exp_dat, held, cc0;
        imem_op = (op == OP_WR_IMEM) || (op == OP_RD_IMEM);
        dmem_op = (op == OP_WR_DMEM) || (op == OP_RD_DMEM);
        wr_op   = (op == OP_WR_IMEM) || (op == OP_WR_DMEM);
        rd_op   = (op == OP_RD_IMEM) || (op == OP_RD_DMEM);
        err     = (op > OP_RUN) || (imem_op && addr >= 32'd512) || (dmem_op && addr >= 32'd1024);
        exp_en  = 0;
        if (op == OP_RUN) exp_en = (abort_at > 0) ? abort_at : int'(data);
        exp_dat = 0;
        if (!err) begin
            if (op == OP_RD_IMEM)      exp_dat = ref_imem[int'(addr)];
            else if (op == OP_RD_DMEM) exp_dat = ref_dmem[int'(addr)];
            else if (op == OP_RUN)     exp_dat = 32'(exp_en);
        end
        exp_lat = 1 + exp_en + ((wr_op && !err) ? 1 : 0) + ((rd_op && !err) ? 2 : 0);

        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        wi0 = n_wen_i; ri0 = n_ren_i; wd0 = n_wen_d; rd0 = n_ren_d; cc0 = cycle_count;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = $urandom; cmd_data = $urandom;

        lat = 1; en_seen = 0; rdy_bad = 0; first_en = cpu_enable;
        while (!rsp_valid && lat <= 400) begin
            if (cmd_ready || (running != cpu_enable)) rdy_bad = 1;
            if (cpu_enable) begin
                en_seen++;
                run_abort = (en_seen == abort_at);
            end else begin
                run_abort = (op != OP_RUN) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        run_abort = 1'b0;

        chk("latency", 64'(lat), 64'(exp_lat));
        chk("first_enable", 64'(first_en), 64'(exp_en > 0));
        chk("enabled_cycles", 64'(en_seen), 64'(exp_en));
        chk("enable_low_at_rsp", 64'({cpu_enable, running}), 64'd0);
        chk("cycle_count_delta", 64'(cycle_count - cc0), 64'(exp_en));
        chk("busy_handshake", 64'(rdy_bad), 64'd0);
        chk("rsp_data", 64'(rsp_data), 64'(exp_dat));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        chk("strobe_counts",
            64'({8'(n_wen_i - wi0), 8'(n_ren_i - ri0), 8'(n_wen_d - wd0), 8'(n_ren_d - rd0)}),
            64'({8'(wr_op && imem_op && !err), 8'(rd_op && imem_op && !err),
                 8'(wr_op && dmem_op && !err), 8'(rd_op && dmem_op && !err)}));

        held = rsp_data; stable_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!rsp_valid || (rsp_data !== held) || (rsp_err !== err) || cmd_ready) stable_bad = 1;
        end
        if (hold > 0) chk("rsp_hold_stable", 64'(stable_bad), 64'd0);

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_retired", 64'({rsp_valid, cmd_ready}), 64'b01);

        if (wr_op && !err) begin
            if (imem_op) begin ref_imem[int'(addr)] = data; wi_q.push_back(int'(addr)); end
            else         begin ref_dmem[int'(addr)] = data; wd_q.push_back(int'(addr)); end
        end
        exp_cc += 32'(exp_en);
        chk("cycle_count_total", 64'(cycle_count), 64'(exp_cc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr, data;
        int          sel, ab, en, guard;
        bit          post_bad;

        // Reset with a RUN command presented: reset must win.
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_addr = 0; cmd_data = 32'd5;
        run_abort = 1'b1; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({cmd_ready, rsp_valid, rsp_err, cpu_enable, running, wen_ext, ren_ext, wen_ext_2, ren_ext_2}),
            64'b100000000);
        chk("reset_words", 64'(rsp_data | cycle_count | addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2), 64'd0);
        cmd_valid = 1'b0; run_abort = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        do_cmd(OP_WR_IMEM, 32'd4, 32'h2008_0005, 0, 0);
        do_cmd(OP_RD_IMEM, 32'd4, 32'h0, 0, 2);
        do_cmd(OP_WR_DMEM, 32'd1024, 32'hDEAD_BEEF, 0, 0);
        do_cmd(3'd7, 32'd0, 32'h1234_5678, 0, 0);
        do_cmd(OP_RUN, 32'd0, 32'd10, 0, 0);
        do_cmd(OP_RUN, 32'd0, 32'd100, 7, 0);
        do_cmd(OP_RUN, 32'd0, 32'd0, 0, 5);
        do_cmd(OP_RUN, 32'd0, 32'd6, 6, 1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            op = OP_NOP; addr = $urandom; data = $urandom; ab = 0;
            case (sel)
                0: op = OP_NOP;
                1, 2: begin op = OP_WR_IMEM; addr = $urandom_range(0, 511); end
                3: if (wi_q.size() > 0) begin op = OP_RD_IMEM; addr = wi_q[$urandom_range(0, wi_q.size() - 1)]; end
                   else begin op = OP_WR_IMEM; addr = $urandom_range(0, 511); end
                4: begin op = OP_WR_DMEM; addr = $urandom_range(0, 1023); end
                5: if (wd_q.size() > 0) begin op = OP_RD_DMEM; addr = wd_q[$urandom_range(0, wd_q.size() - 1)]; end
                   else begin op = OP_WR_DMEM; addr = $urandom_range(0, 1023); end
                6, 7: begin
                    op = OP_RUN; data = $urandom_range(0, 40);
                    if (data != 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, int'(data));
                end
                8: op = 3'($urandom_range(6, 7));
                default: begin
                    op = 3'($urandom_range(1, 4));
                    addr = (((op == OP_WR_IMEM) || (op == OP_RD_IMEM)) ? 32'd512 : 32'd1024)
                           << $urandom_range(0, 21);
                    addr = addr | 32'($urandom_range(0, 511));
                end
            endcase
            do_cmd(op, addr, data, ab, $urandom_range(0, 3));
        end

        // Reset on the 20th enabled cycle of RUN 50: enable drops, response discarded.
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_data = 32'd50; cmd_addr = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        en = 0; guard = 0;
        while (guard < 100) begin
            if (cpu_enable) en++;
            if (en == 20) break;
            @(posedge clk); #1;
            guard++;
        end
        chk("run_before_reset", 64'(en), 64'd20);
        chk("cc_before_reset", 64'(cycle_count), 64'(exp_cc + 32'd19));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_run", 64'({cpu_enable, running, rsp_valid, cmd_ready}), 64'b0001);
        chk("reset_cycle_count", 64'(cycle_count), 64'd0);
        rst = 1'b0; exp_cc = 0; post_bad = 0;
        rsp_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid || cpu_enable || !cmd_ready) post_bad = 1;
        end
        rsp_ready = 1'b0;
        chk("no_rsp_after_reset", 64'(post_bad), 64'd0);

        do_cmd(OP_RUN, 32'd0, 32'd3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
